reg_writeback_unit: RTL

- Write-side front end for the 32x32 register file. It merges two writeback sources into the register file's single write port (writeReg/writeData/writeEnable):
  - a single-cycle ALU path;
  - a long-latency memory/multiply path, buffered in a FIFO with a valid/ready handshake.
- It keeps a scoreboard of destination registers with outstanding long-latency results, so issue logic can stall on RAW hazards.

---
 rtl/reg_writeback_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_writeback_unit.sv
// Register-file write front end: merges a single-cycle ALU result stream and a FIFO-buffered
// long-latency stream into one write port, and tracks outstanding long-latency destinations.
module reg_writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          aluValid,
  input  logic [ADDR_WIDTH-1:0]         aluReg,
  input  logic [DATA_WIDTH-1:0]         aluData,
  input  logic                          memValid,
  output logic                          memReady,
  input  logic [ADDR_WIDTH-1:0]         memReg,
  input  logic [DATA_WIDTH-1:0]         memData,
  input  logic                          issueValid,
  input  logic [ADDR_WIDTH-1:0]         issueReg,
  output logic [2**ADDR_WIDTH-1:0]      pendingMask,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic [ADDR_WIDTH-1:0]         writeReg,
  output logic [DATA_WIDTH-1:0]         writeData,
  output logic                          writeEnable
);
  localparam int NREG = 2**ADDR_WIDTH;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] r_fifo_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [NREG-1:0]       r_pending;

  logic                  w_alu_sel;
  logic                  w_pop;
  logic                  w_push;
  logic [ADDR_WIDTH-1:0] w_head_reg;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [NREG-1:0]       w_set;
  logic [NREG-1:0]       w_clr;

  // A dropped ALU write to r0 leaves the slot free for the FIFO head.
  assign w_alu_sel   = aluValid && (aluReg != '0);
  assign w_pop       = !w_alu_sel && (r_count != '0);
  assign memReady    = resetN && (r_count != FULL_COUNT);
  assign w_push      = memValid && memReady && (memReg != '0);
  assign w_head_reg  = r_fifo_reg[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_reg[r_wr_ptr]  <= memReg;
      r_fifo_data[r_wr_ptr] <= memData;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
    end else begin
      writeEnable <= w_alu_sel || w_pop;
      if (w_alu_sel) begin
        writeReg  <= aluReg;
        writeData <= aluData;
      end else if (w_pop) begin
        writeReg  <= w_head_reg;
        writeData <= w_head_data;
      end
    end
  end

  // Per-register set/clear decode; register 0 is never tracked.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      assign w_set[gi] = (gi != 0) && issueValid && (issueReg == ADDR_WIDTH'(gi));
      assign w_clr[gi] = w_pop && (w_head_reg == ADDR_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_pending <= '0;
    else         r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign pendingMask = r_pending;
  assign fifoCount   = r_count;
endmodule
